// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory bundle; master = controller, slave = datapath side.
interface multicycle_ctrl_if #(parameter int OPC_W = 4);
  logic [OPC_W-1:0] opcode;
  logic zero_flag, mem_ready;
  logic im_req, dm_req, dm_we, ir_we, mdr_we, pc_we, rf_we, rf_wsel, alu_src_b;
  logic halted, trap, timeout;
  logic [1:0] pc_src, alu_op;
  logic [3:0] state_o;
  modport master (
    input  opcode, zero_flag, mem_ready,
    output im_req, dm_req, dm_we, ir_we, mdr_we, pc_we, pc_src, rf_we, rf_wsel,
           alu_src_b, alu_op, halted, trap, timeout, state_o
  );
  modport slave (
    output opcode, zero_flag, mem_ready,
    input  im_req, dm_req, dm_we, ir_we, mdr_we, pc_we, pc_src, rf_we, rf_wsel,
           alu_src_b, alu_op, halted, trap, timeout, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer with memory wait timeout, HALT and TRAP.
// Optional retired-instruction counter enabled by defining INSTR_CNT_EN.
module multicycle_ctrl #(
  parameter int OPC_W        = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_if.master bus
`ifdef INSTR_CNT_EN
  , output logic [CNT_W-1:0] instr_count_o
`endif
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3, EXEC_I = 4'd4,
    ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7, WB_ALU = 4'd8, WB_MEM = 4'd9,
    BRANCH = 4'd10, JUMP = 4'd11, HALT = 4'd12, TRAP = 4'd13
  } state_t;
  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  // last waiting cycle allowed: counter already holds MEM_WAIT_MAX-1 earlier waits
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  logic rdy;
  logic [3:0] op4;
  assign rdy = bus.mem_ready;
  assign op4 = bus.opcode[3:0];
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    to_d = to_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH, MEM_RD, MEM_WR:
        if (rdy) state_d = state_q == FETCH ? DECODE : state_q == MEM_RD ? WB_MEM : FETCH;
        else if (cnt_q == LAST) begin
          state_d = TRAP;
          to_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      DECODE: state_d = (bus.opcode >> 4) != '0 ? TRAP :
                        op4 == 4'd0 ? EXEC_R : op4 == 4'd1 ? EXEC_I :
                        op4[3:1] == 3'd1 ? ADDR : op4 == 4'd4 ? BRANCH :
                        op4 == 4'd5 ? JUMP : op4 == 4'hF ? HALT : TRAP;
      EXEC_R, EXEC_I: state_d = WB_ALU;
      ADDR: state_d = op4[0] ? MEM_WR : MEM_RD;
      WB_ALU, WB_MEM, BRANCH, JUMP: state_d = FETCH;
      HALT, TRAP: state_d = state_q;
      default: state_d = TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  assign bus.im_req    = state_q == FETCH;
  assign bus.ir_we     = state_q == FETCH && rdy;
  assign bus.pc_we     = (state_q == FETCH && rdy) || state_q == JUMP || (state_q == BRANCH && bus.zero_flag);
  assign bus.pc_src    = state_q == JUMP ? 2'd2 : (state_q == BRANCH && bus.zero_flag) ? 2'd1 : 2'd0;
  assign bus.dm_req    = state_q == MEM_RD || state_q == MEM_WR;
  assign bus.dm_we     = state_q == MEM_WR;
  assign bus.mdr_we    = state_q == MEM_RD && rdy;
  assign bus.rf_we     = state_q == WB_ALU || state_q == WB_MEM;
  assign bus.rf_wsel   = state_q == WB_MEM;
  assign bus.alu_src_b = state_q == EXEC_I || state_q == ADDR;
  assign bus.alu_op    = (state_q == EXEC_I || state_q == ADDR) ? 2'd1 : state_q == BRANCH ? 2'd2 : 2'd0;
  assign bus.halted    = state_q == HALT;
  assign bus.trap      = state_q == TRAP;
  assign bus.timeout   = to_q;
  assign bus.state_o   = state_q;
`ifdef INSTR_CNT_EN
  logic [CNT_W-1:0] ic_q, ic_d;
  // retire on the return to FETCH from any instruction-final state
  assign ic_d = (state_d == FETCH && (state_q == WB_ALU || state_q == WB_MEM || state_q == MEM_WR ||
                 state_q == BRANCH || state_q == JUMP)) ? ic_q + 1'b1 : ic_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ic_q <= '0;
    else ic_q <= ic_d;
  assign instr_count_o = ic_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction cycle scripts (expected state + strobes) built from opcode and wait counts.
module tb_multicycle_ctrl;
  localparam int OPC_W = 5;
  localparam int MW = 15;
  localparam int CW = 4;
  localparam logic [15:0] IM = 16'h8000, DMR = 16'h4000, DWE = 16'h2000, IRW = 16'h1000,
    MDW = 16'h0800, PCW = 16'h0400, PS2 = 16'h0200, PS1 = 16'h0100, RFW = 16'h0080,
    RFS = 16'h0040, ASB = 16'h0020, AOS = 16'h0010, AOA = 16'h0008, HLT = 16'h0004,
    TRP = 16'h0002, TMO = 16'h0001;
  typedef struct {
    logic [3:0] st;
    logic rdy;
    logic zf;
    logic [OPC_W-1:0] op;
    logic [15:0] o;
    int ic;
  } cyc_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0, n_err = 0, cur_ic = 0;
  logic [OPC_W-1:0] cur_op;
  logic cur_zf;
  logic [15:0] obs;
  cyc_t q[$];
  multicycle_ctrl_if #(.OPC_W(OPC_W)) bus();
`ifdef INSTR_CNT_EN
  logic [CW-1:0] instr_count;
`endif
  multicycle_ctrl #(.OPC_W(OPC_W), .MEM_WAIT_MAX(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef INSTR_CNT_EN
    , .instr_count_o(instr_count)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {bus.im_req, bus.dm_req, bus.dm_we, bus.ir_we, bus.mdr_we, bus.pc_we, bus.pc_src,
                bus.rf_we, bus.rf_wsel, bus.alu_src_b, bus.alu_op, bus.halted, bus.trap, bus.timeout};
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic r();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic push(logic [3:0] st, logic rdy, logic [15:0] o);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.zf = cur_zf; c.op = cur_op; c.o = o; c.ic = cur_ic;
    q.push_back(c);
  endtask
  task automatic tail(logic [3:0] st, logic [15:0] o);
    repeat (4) push(st, r(), o);
  endtask
  // one instruction: fw fetch wait cycles, mw data-memory wait cycles; waits >= MW end in a timeout TRAP
  task automatic add_instr(int op, int fw, int mw, logic zf);
    logic [3:0] s;
    logic [15:0] o;
    cur_op = OPC_W'(op);
    cur_zf = zf;
    for (int i = 0; i < fw && i < MW; i++) push(4'd1, 1'b0, IM);
    if (fw >= MW) begin tail(4'd13, TRP | TMO); return; end
    push(4'd1, 1'b1, IM | IRW | PCW);
    push(4'd2, r(), 16'h0);
    case (op)
      0: begin push(4'd3, r(), 16'h0); push(4'd8, r(), RFW); end
      1: begin push(4'd4, r(), ASB | AOA); push(4'd8, r(), RFW); end
      2, 3: begin
        s = op == 2 ? 4'd6 : 4'd7;
        o = op == 2 ? DMR : DMR | DWE;
        push(4'd5, r(), ASB | AOA);
        for (int i = 0; i < mw && i < MW; i++) push(s, 1'b0, o);
        if (mw >= MW) begin tail(4'd13, TRP | TMO); return; end
        if (op == 2) begin push(4'd6, 1'b1, DMR | MDW); push(4'd9, r(), RFW | RFS); end
        else push(4'd7, 1'b1, DMR | DWE);
      end
      4: push(4'd10, r(), AOS | (zf ? PCW | PS1 : 16'h0));
      5: push(4'd11, r(), PCW | PS2);
      15: begin tail(4'd12, HLT); return; end
      default: begin tail(4'd13, TRP); return; end
    endcase
    cur_ic++;
  endtask
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      bus.opcode = c.op;
      bus.zero_flag = c.zf;
      bus.mem_ready = c.rdy;
      #1;
      chk($sformatf("state op=%0d", c.op), 32'(bus.state_o), 32'(c.st));
      chk($sformatf("outs st=%0d", c.st), 32'(obs), 32'(c.o));
`ifdef INSTR_CNT_EN
      chk($sformatf("icnt st=%0d", c.st), 32'(instr_count), 32'(CW'(c.ic)));
`endif
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst state", 32'(bus.state_o), 32'd0);
    chk("rst outs", 32'(obs), 32'd0);
`ifdef INSTR_CNT_EN
    chk("rst icnt", 32'(instr_count), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cur_ic = 0;
    cur_op = '0;
    cur_zf = 1'b0;
    push(4'd0, r(), 16'h0);
  endtask
  initial begin
    bus.opcode = '0;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    do_reset();
    add_instr(0, 0, 0, 1'b0);
    add_instr(2, 0, 3, 1'b0);
    add_instr(4, 0, 0, 1'b1);
    add_instr(4, 0, 0, 1'b0);
    add_instr(0, 14, 0, 1'b1);
    add_instr(3, 2, 14, 1'b0);
    add_instr(5, 1, 0, 1'b1);
    add_instr(1, 0, 0, 1'b0);
    for (int i = 0; i < 17; i++) add_instr(0, 0, 0, r());
    for (int i = 0; i < 30; i++)
      add_instr($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), r());
    add_instr(0, 15, 0, 1'b0);
    run_q();
    do_reset();
    add_instr(1, 1, 0, 1'b0);
    add_instr(2, 0, 15, 1'b0);
    run_q();
    do_reset();
    add_instr(15, 0, 0, 1'b0);
    run_q();
    do_reset();
    add_instr(6, 0, 0, 1'b0);
    run_q();
    do_reset();
    add_instr(16, 0, 0, 1'b0);
    run_q();
    for (int i = 0; i < 3; i++) begin
      do_reset();
      add_instr($urandom_range(0, 1) == 1 ? $urandom_range(6, 14) : $urandom_range(16, 31), 0, 0, r());
      run_q();
    end
    do_reset();
    add_instr(0, 0, 0, 1'b0);
    cur_op = OPC_W'(3);
    push(4'd1, 1'b1, IM | IRW | PCW);
    push(4'd2, r(), 16'h0);
    push(4'd5, r(), ASB | AOA);
    push(4'd7, 1'b0, DMR | DWE);
    push(4'd7, 1'b0, DMR | DWE);
    run_q();
    do_reset();
    run_q();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
